ysyx_23060337_gpr_file: RTL and testbench

General-purpose register file for the NPC core: 32 × XLEN architectural registers with two registered read ports, one write-back port and a per-register busy scoreboard. The decode stage reads operands and scoreboard state; the write-back stage updates registers and releases busy bits. x0 is hardwired to zero and is never busy.

---
 rtl/ysyx_23060337_gpr_file.sv | 86 ++++++++
 tb/tb_ysyx_23060337_gpr_file.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060337_gpr_file.sv
// ysyx_23060337_gpr_file: NPC general-purpose register file.
// 32 x XLEN registers with two registered read ports, one write-back port
// and a per-register busy scoreboard. x0 reads as zero and is never busy.
// Optional feature: define YSYX_23060337_GPR_WB_BYPASS_EN to forward a
// same-edge write-back to a read port addressing the same register.
module ysyx_23060337_gpr_file #(
  parameter int unsigned       NR_REG    = 32,
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VAL = '0,
  localparam int unsigned      AW        = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ren,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd
);

  logic [XLEN-1:0]   rf [NR_REG-1:1];
  logic [NR_REG-1:0] busy;
  logic [NR_REG-1:0] busy_next;
  logic [XLEN-1:0]   rd1_next;
  logic [XLEN-1:0]   rd2_next;
  logic              wr_valid;

  assign wr_valid = wen && (waddr != '0);

  // Register storage: async reset to RESET_VAL, write-back on posedge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NR_REG; i++) begin
        rf[i] <= RESET_VAL;
      end
    end else if (wr_valid) begin
      rf[waddr] <= wdata;
    end
  end

  // Read-port data selection: x0 is zero, optional write-back forwarding
  always_comb begin
    rd1_next = (raddr1 == '0) ? '0 : rf[raddr1];
    rd2_next = (raddr2 == '0) ? '0 : rf[raddr2];
`ifdef YSYX_23060337_GPR_WB_BYPASS_EN
    if (wr_valid && (waddr == raddr1)) rd1_next = wdata;
    if (wr_valid && (waddr == raddr2)) rd2_next = wdata;
`endif
  end

  // Registered read ports; hold previous data when ren is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else if (ren) begin
      rdata1 <= rd1_next;
      rdata2 <= rd2_next;
    end
  end

  // Scoreboard next state: issue sets, write-back clears, set wins on conflict
  always_comb begin
    busy_next = busy;
    if (wr_valid) busy_next[waddr] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy1 = busy[raddr1];
  assign busy2 = busy[raddr2];

endmodule

// File: tb/tb_ysyx_23060337_gpr_file.sv
// tb_ysyx_23060337_gpr_file: directed self-checking bench for the GPR file.
module tb_ysyx_23060337_gpr_file;

  localparam logic [31:0] RV = 32'hCAFE_0001;

  logic        clk;
  logic        rst;
  logic        ren;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_en;
  logic [4:0]  issue_rd;

  int checks = 0;
  int passed = 0;

  ysyx_23060337_gpr_file #(
    .NR_REG   (32),
    .XLEN     (32),
    .RESET_VAL(RV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .busy1   (busy1),
    .busy2   (busy2),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .issue_en(issue_en),
    .issue_rd(issue_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren = 1'b0; wen = 1'b0; issue_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0; issue_rd = '0;
    step(); step();
    rst = 1'b0;
    wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_0055;
    step();
    wen = 1'b0; issue_en = 1'b1; issue_rd = 5'd9;
    step();
    issue_en = 1'b0; ren = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;
    step();
    checks++;
    if (rdata1 !== 32'h55) $display("FAIL pre_reset_read: got %h expected %h", rdata1, 32'h55);
    else passed++;
    // Assert reset mid-cycle during a write
    ren = 1'b0; wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_DEAD;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (rdata1 !== 32'h0) $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0);
    else passed++;
    checks++;
    if (rdata2 !== 32'h0) $display("FAIL reset_rdata2: got %h expected %h", rdata2, 32'h0);
    else passed++;
    step();
    rst = 1'b0; wen = 1'b0;
    ren = 1'b1; raddr1 = 5'd5; raddr2 = 5'd9;
    step();
    checks++;
    if (rdata1 !== RV) $display("FAIL reset_val_x5: got %h expected %h", rdata1, RV);
    else passed++;
    checks++;
    if (rdata2 !== RV) $display("FAIL reset_val_x9: got %h expected %h", rdata2, RV);
    else passed++;
    ren = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      checks++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0)
        $display("FAIL reset_busy[%0d]: got %b%b expected 00", a, busy1, busy2);
      else passed++;
    end
  endtask

  task automatic test_basic_rw();
    idle();
    wen = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    step();
    wen = 1'b0; ren = 1'b1; raddr1 = 5'd3; raddr2 = 5'd0;
    step();
    checks++;
    if (rdata1 !== 32'h1234_5678) $display("FAIL rw_x3: got %h expected %h", rdata1, 32'h1234_5678);
    else passed++;
    checks++;
    if (rdata2 !== 32'h0) $display("FAIL rw_x0_port2: got %h expected %h", rdata2, 32'h0);
    else passed++;
    ren = 1'b0; wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    step();
    wen = 1'b0; ren = 1'b1; raddr1 = 5'd0; raddr2 = 5'd3;
    step();
    checks++;
    if (rdata1 !== 32'h0) $display("FAIL rw_x0_write_ignored: got %h expected %h", rdata1, 32'h0);
    else passed++;
    checks++;
    if (rdata2 !== 32'h1234_5678) $display("FAIL rw_x3_port2: got %h expected %h", rdata2, 32'h1234_5678);
    else passed++;
    ren = 1'b0;
  endtask

  task automatic test_hazard();
    logic [31:0] exp;
`ifdef YSYX_23060337_GPR_WB_BYPASS_EN
    exp = 32'h2;
`else
    exp = 32'h1;
`endif
    idle();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h1;
    step();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h2; ren = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    step();
    checks++;
    if (rdata1 !== exp) $display("FAIL hazard_same_edge1: got %h expected %h", rdata1, exp);
    else passed++;
    checks++;
    if (rdata2 !== exp) $display("FAIL hazard_same_edge2: got %h expected %h", rdata2, exp);
    else passed++;
    wen = 1'b0;
    step();
    checks++;
    if (rdata1 !== 32'h2) $display("FAIL hazard_followup: got %h expected %h", rdata1, 32'h2);
    else passed++;
    ren = 1'b0;
  endtask

  task automatic test_hold();
    idle();
    wen = 1'b1; waddr = 5'd4; wdata = 32'h4444_4444;
    step();
    wen = 1'b0; ren = 1'b1; raddr1 = 5'd3;
    step();
    checks++;
    if (rdata1 !== 32'h1234_5678) $display("FAIL hold_load: got %h expected %h", rdata1, 32'h1234_5678);
    else passed++;
    ren = 1'b0; raddr1 = 5'd4;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (rdata1 !== 32'h1234_5678)
        $display("FAIL hold_cycle%0d: got %h expected %h", c, rdata1, 32'h1234_5678);
      else passed++;
    end
  endtask

  task automatic test_scoreboard();
    idle();
    raddr1 = 5'd9;
    issue_en = 1'b1; issue_rd = 5'd9;
    #1;
    checks++;
    if (busy1 !== 1'b0) $display("FAIL sb_before_issue: got %b expected 0", busy1);
    else passed++;
    step();
    issue_en = 1'b0;
    checks++;
    if (busy1 !== 1'b1) $display("FAIL sb_issue: got %b expected 1", busy1);
    else passed++;
    issue_en = 1'b1; issue_rd = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    step();
    issue_en = 1'b0; wen = 1'b0;
    checks++;
    if (busy1 !== 1'b1) $display("FAIL sb_set_wins: got %b expected 1", busy1);
    else passed++;
    issue_en = 1'b1; issue_rd = 5'd9;
    step();
    issue_en = 1'b0;
    checks++;
    if (busy1 !== 1'b1) $display("FAIL sb_reissue: got %b expected 1", busy1);
    else passed++;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h9A;
    step();
    wen = 1'b0;
    checks++;
    if (busy1 !== 1'b0) $display("FAIL sb_clear: got %b expected 0", busy1);
    else passed++;
    issue_en = 1'b1; issue_rd = 5'd0;
    step();
    issue_en = 1'b0; raddr1 = 5'd0;
    #1;
    checks++;
    if (busy1 !== 1'b0) $display("FAIL sb_x0_never_busy: got %b expected 0", busy1);
    else passed++;
  endtask

  task automatic test_parallel();
    idle();
    issue_en = 1'b1; issue_rd = 5'd6;
    step();
    issue_en = 1'b1; issue_rd = 5'd4; wen = 1'b1; waddr = 5'd6; wdata = 32'h66;
    raddr1 = 5'd4; raddr2 = 5'd6;
    #1;
    checks++;
    if (busy2 !== 1'b1) $display("FAIL par_clear_not_early: got %b expected 1", busy2);
    else passed++;
    step();
    idle();
    checks++;
    if (busy1 !== 1'b1) $display("FAIL par_set_x4: got %b expected 1", busy1);
    else passed++;
    checks++;
    if (busy2 !== 1'b0) $display("FAIL par_clear_x6: got %b expected 0", busy2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'hA0A0_0010; vals[1] = 32'hB1B1_0011;
    vals[2] = 32'hC2C2_0012; vals[3] = 32'hD3D3_0013;
    idle();
    // Write x10..x13 on consecutive edges while reading the previous write
    for (int k = 0; k < 5; k++) begin
      wen = (k < 4); waddr = 5'(10 + k); wdata = (k < 4) ? vals[k] : 32'h0;
      ren = (k > 0); raddr1 = 5'(9 + k); raddr2 = 5'(13 - k);
      step();
      if (k > 0) begin
        checks++;
        if (rdata1 !== vals[k-1])
          $display("FAIL b2b_read_x%0d: got %h expected %h", 9 + k, rdata1, vals[k-1]);
        else passed++;
      end
    end
    idle();
    raddr1 = 5'd12; raddr2 = 5'd10; ren = 1'b1;
    step();
    ren = 1'b0;
    checks++;
    if (rdata1 !== vals[2]) $display("FAIL b2b_final_x12: got %h expected %h", rdata1, vals[2]);
    else passed++;
    checks++;
    if (rdata2 !== vals[0]) $display("FAIL b2b_final_x10: got %h expected %h", rdata2, vals[0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_hazard();
    test_hold();
    test_scoreboard();
    test_parallel();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
